// File: rtl/cpu_pkg.sv
// Shared types and field positions for the 8-bit common-bus CPU control path.
package cpu_pkg;

    typedef enum logic [3:0] {
        OpNop  = 4'd0,
        OpLdi  = 4'd1,
        OpAdd  = 4'd2,
        OpSub  = 4'd3,
        OpAnd  = 4'd4,
        OpOr   = 4'd5,
        OpXor  = 4'd6,
        OpJmp  = 4'd7,
        OpHalt = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluAnd = 3'd2,
        AluOr  = 3'd3,
        AluXor = 3'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        BUS_PC  = 2'b00,
        BUS_IR  = 2'b01,
        BUS_ALU = 2'b10,
        BUS_RF  = 2'b11
    } bus_sel_t;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StSelA,
        StRdA,
        StSelB,
        StRdB,
        StSelD,
        StWb,
        StJmp,
        StHalt
    } ctrl_state_t;

    typedef enum logic [2:0] {
        ClsNop,
        ClsLdi,
        ClsAlu,
        ClsJmp,
        ClsHalt
    } instr_class_t;

    localparam int unsigned OpcodeMsb = 13;
    localparam int unsigned OpcodeLsb = 10;
    localparam int unsigned RdMsb     = 9;
    localparam int unsigned RdLsb     = 8;
    localparam int unsigned RsMsb     = 7;
    localparam int unsigned RsLsb     = 6;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: instruction class, ALU function and illegal flag.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] iclass,
    output logic [2:0] alu_op,
    output logic       illegal
);

    always_comb begin
        iclass  = ClsNop;
        alu_op  = AluAdd;
        illegal = 1'b0;
        case (opcode)
            OpNop:  iclass = ClsNop;
            OpLdi:  iclass = ClsLdi;
            OpAdd:  begin iclass = ClsAlu; alu_op = AluAdd; end
            OpSub:  begin iclass = ClsAlu; alu_op = AluSub; end
            OpAnd:  begin iclass = ClsAlu; alu_op = AluAnd; end
            OpOr:   begin iclass = ClsAlu; alu_op = AluOr;  end
            OpXor:  begin iclass = ClsAlu; alu_op = AluXor; end
            OpJmp:  iclass = ClsJmp;
            OpHalt: iclass = ClsHalt;
            // Undefined opcodes behave as NOP but are flagged.
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: fetch over a req/valid handshake, decode, then one bus
// transfer per cycle through the register-select, operand and write-back steps.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instr_valid,
    input  logic [13:0] ir,
    output logic        instr_req,
    output logic        ir_load_en,
    output logic        pc_inc,
    output logic        pc_load_en,
    output logic        sel_field_load_en,
    output logic [1:0]  reg_address,
    output logic        alu_src1_load_en,
    output logic        alu_src2_load_en,
    output logic        rf_write_read,
    output logic [1:0]  data_bus_sel,
    output logic [2:0]  alu_op,
    output logic        halted,
    output logic        illegal_op
);

    ctrl_state_t state_q, state_d;
    logic [3:0]  opcode_q;
    logic [1:0]  rd_q, rs_q;
    logic        illegal_q, illegal_d;
    bus_sel_t    bus_sel;

    logic [3:0]  dec_opcode;
    logic [2:0]  dec_class;
    logic [2:0]  dec_alu_op;
    logic        dec_illegal;
    logic        unused_ir_low;

    assign unused_ir_low = ^ir[5:0];

    // DECODE looks at the live IR; every later state works off the captured opcode.
    assign dec_opcode = (state_q == StDecode) ? ir[OpcodeMsb:OpcodeLsb] : opcode_q;

    instr_decode u_decode (
        .opcode  (dec_opcode),
        .iclass  (dec_class),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StFetch;
            opcode_q  <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            if (state_q == StDecode) begin
                opcode_q <= ir[OpcodeMsb:OpcodeLsb];
                rd_q     <= ir[RdMsb:RdLsb];
                rs_q     <= ir[RsMsb:RsLsb];
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        illegal_d         = illegal_q;
        instr_req         = 1'b0;
        ir_load_en        = 1'b0;
        pc_inc            = 1'b0;
        pc_load_en        = 1'b0;
        sel_field_load_en = 1'b0;
        reg_address       = 2'b00;
        alu_src1_load_en  = 1'b0;
        alu_src2_load_en  = 1'b0;
        rf_write_read     = 1'b0;
        bus_sel           = BUS_PC;
        alu_op            = 3'd0;
        halted            = 1'b0;
        // Outputs are forced quiet for the whole time reset is held.
        if (reset_n) begin
            unique case (state_q)
                StFetch: begin
                    instr_req = 1'b1;
                    if (instr_valid) begin
                        ir_load_en = 1'b1;
                        pc_inc     = 1'b1;
                        state_d    = StDecode;
                    end
                end
                StDecode: begin
                    if (dec_illegal) illegal_d = 1'b1;
                    case (dec_class)
                        ClsLdi:  state_d = StSelD;
                        ClsAlu:  state_d = StSelA;
                        ClsJmp:  state_d = StJmp;
                        ClsHalt: state_d = StHalt;
                        default: state_d = StFetch;
                    endcase
                end
                StSelA: begin
                    reg_address       = rd_q;
                    sel_field_load_en = 1'b1;
                    state_d           = StRdA;
                end
                StRdA: begin
                    bus_sel          = BUS_RF;
                    alu_src1_load_en = 1'b1;
                    state_d          = StSelB;
                end
                StSelB: begin
                    reg_address       = rs_q;
                    sel_field_load_en = 1'b1;
                    state_d           = StRdB;
                end
                StRdB: begin
                    bus_sel          = BUS_RF;
                    alu_src2_load_en = 1'b1;
                    state_d          = StSelD;
                end
                StSelD: begin
                    reg_address       = rd_q;
                    sel_field_load_en = 1'b1;
                    state_d           = StWb;
                end
                StWb: begin
                    rf_write_read = 1'b1;
                    if (dec_class == ClsAlu) begin
                        bus_sel = BUS_ALU;
                        alu_op  = dec_alu_op;
                    end else begin
                        bus_sel = BUS_IR;
                    end
                    state_d = StFetch;
                end
                StJmp: begin
                    bus_sel    = BUS_IR;
                    pc_load_en = 1'b1;
                    state_d    = StFetch;
                end
                StHalt: halted = 1'b1;
                default: state_d = StFetch;
            endcase
        end
    end

    assign data_bus_sel = bus_sel;
    assign illegal_op   = illegal_q;

endmodule
